// File: rtl/encoder_83_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// I/EI flow master->slave; Y/GS/EO flow slave->master.
interface encoder_83_if;
    logic [7:0] I;
    logic       EI;
    logic [2:0] Y;
    logic       GS;
    logic       EO;

    modport master (
        output I,
        output EI,
        input  Y,
        input  GS,
        input  EO
    );

    modport slave (
        input  I,
        input  EI,
        output Y,
        output GS,
        output EO
    );
endinterface

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder with enable and cascade outputs.
// Ports: clk, rst (sync, active-high), bus.I/EI in, bus.Y/GS/EO out.
module encoder_83 #(
    parameter bit REG_IN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    encoder_83_if.slave  bus
);

    logic [7:0] req_s;
    logic       en_s;

    // Optional input stage; clears to "disabled" so a reset
    // flushes anything in flight.
    if (REG_IN) begin : g_in_reg
        logic [7:0] i_q;
        logic       ei_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                i_q  <= 8'd0;
                ei_q <= 1'b0;
            end else begin
                i_q  <= bus.I;
                ei_q <= bus.EI;
            end
        end

        assign req_s = i_q;
        assign en_s  = ei_q;
    end else begin : g_in_comb
        assign req_s = bus.I;
        assign en_s  = bus.EI;
    end

    logic [2:0] y_d, y_q;
    logic       gs_d, gs_q;
    logic       eo_d, eo_q;

    // Ascending scan: the last set bit seen is the highest,
    // which gives bit 7 strict priority.
    always_comb begin
        y_d  = 3'd0;
        gs_d = 1'b0;
        eo_d = 1'b0;
        if (en_s) begin
            eo_d = (req_s == 8'd0);
            gs_d = (req_s != 8'd0);
            for (int k = 0; k < 8; k++) begin
                if (req_s[k]) begin
                    y_d = 3'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= 3'd0;
            gs_q <= 1'b0;
            eo_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            gs_q <= gs_d;
            eo_q <= eo_d;
        end
    end

    assign bus.Y  = y_q;
    assign bus.GS = gs_q;
    assign bus.EO = eo_q;

endmodule

// File: tb/tb_encoder_83.sv
// Bench for encoder_83: REG_IN=0 and REG_IN=1 instances driven
// in lockstep, checked against a behavioural model.
module tb_encoder_83;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encoder_83_if bus0 ();
    encoder_83_if bus1 ();

    encoder_83 #(.REG_IN(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    encoder_83 #(.REG_IN(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] exp0, exp1;
    logic [7:0] st_i = 8'd0;
    logic       st_e = 1'b0;

    // {Y, GS, EO} from the truth table; index via floor(log2).
    function automatic logic [4:0] ref_out(
        input logic [7:0] i,
        input logic       e
    );
        int v;
        int k;
        if (!e) return 5'b000_0_0;
        if (i == 8'd0) return 5'b000_0_1;
        v = int'(i);
        k = 0;
        while (v > 1) begin
            v = v / 2;
            k++;
        end
        return {k[2:0], 2'b10};
    endfunction

    function automatic logic [4:0] out0();
        return {bus0.Y, bus0.GS, bus0.EO};
    endfunction

    function automatic logic [4:0] out1();
        return {bus1.Y, bus1.GS, bus1.EO};
    endfunction

    // Drive one cycle, then advance the model past the edge.
    task automatic cyc(
        input logic       r,
        input logic [7:0] i,
        input logic       e
    );
        rst     = r;
        bus0.I  = i;
        bus0.EI = e;
        bus1.I  = i;
        bus1.EI = e;
        @(posedge clk);
        #1;
        exp0 = r ? 5'd0 : ref_out(i, e);
        exp1 = r ? 5'd0 : ref_out(st_i, st_e);
        st_i = r ? 8'd0 : i;
        st_e = r ? 1'b0 : e;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            cyc(1'b1, 8'hFF, 1'b1);
            n_tests++;
            if (out0() !== 5'd0) begin
                n_fail++;
                $display("FAIL reset0 got %b want %b", out0(), 5'd0);
            end
            n_tests++;
            if (out1() !== 5'd0) begin
                n_fail++;
                $display("FAIL reset1 got %b want %b", out1(), 5'd0);
            end
        end
        cyc(1'b0, 8'hFF, 1'b1);
        n_tests++;
        if (out0() !== 5'b111_1_0) begin
            n_fail++;
            $display("FAIL rel0 got %b want %b", out0(), 5'b111_1_0);
        end
        n_tests++;
        if (out1() !== 5'd0) begin
            n_fail++;
            $display("FAIL rel1a got %b want %b", out1(), 5'd0);
        end
        cyc(1'b0, 8'hFF, 1'b1);
        n_tests++;
        if (out1() !== 5'b111_1_0) begin
            n_fail++;
            $display("FAIL rel1b got %b want %b", out1(), 5'b111_1_0);
        end
    endtask

    task automatic test_enable();
        cyc(1'b0, 8'd200, 1'b1);
        n_tests++;
        if (out0() !== 5'b111_1_0) begin
            n_fail++;
            $display("FAIL en_on got %b want %b", out0(), 5'b111_1_0);
        end
        cyc(1'b0, 8'd200, 1'b0);
        n_tests++;
        if (out0() !== 5'd0) begin
            n_fail++;
            $display("FAIL en_off got %b want %b", out0(), 5'd0);
        end
        n_tests++;
        if (out1() !== exp1) begin
            n_fail++;
            $display("FAIL en_off1 got %b want %b", out1(), exp1);
        end
        cyc(1'b0, 8'd200, 1'b0);
        n_tests++;
        if (out1() !== 5'd0) begin
            n_fail++;
            $display("FAIL en_off1b got %b want %b", out1(), 5'd0);
        end
    endtask

    task automatic test_priority();
        logic [7:0] pat [3] = '{8'd100, 8'd50, 8'd1};
        logic [4:0] want [3] = '{5'b110_1_0, 5'b101_1_0, 5'b000_1_0};
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, pat[n], 1'b1);
            n_tests++;
            if (out0() !== want[n]) begin
                n_fail++;
                $display("FAIL prio I=%0d got %b want %b",
                         pat[n], out0(), want[n]);
            end
            n_tests++;
            if (out1() !== exp1) begin
                n_fail++;
                $display("FAIL prio1 I=%0d got %b want %b",
                         pat[n], out1(), exp1);
            end
        end
    endtask

    task automatic test_zero_walk();
        logic [4:0] w;
        cyc(1'b0, 8'd0, 1'b1);
        n_tests++;
        if (out0() !== 5'b000_0_1) begin
            n_fail++;
            $display("FAIL zero got %b want %b", out0(), 5'b000_0_1);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 8'(1 << k), 1'b1);
            w = {k[2:0], 2'b10};
            n_tests++;
            if (out0() !== w) begin
                n_fail++;
                $display("FAIL walk k=%0d got %b want %b", k, out0(), w);
            end
            n_tests++;
            if (out1() !== exp1) begin
                n_fail++;
                $display("FAIL walk1 k=%0d got %b want %b",
                         k, out1(), exp1);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 8'd50, 1'b1);
        cyc(1'b1, 8'd50, 1'b1);
        n_tests++;
        if (out0() !== 5'd0 || out1() !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_rst got %b/%b want 0/0", out0(), out1());
        end
        cyc(1'b0, 8'd50, 1'b1);
        n_tests++;
        if (out0() !== 5'b101_1_0) begin
            n_fail++;
            $display("FAIL mid_a0 got %b want %b", out0(), 5'b101_1_0);
        end
        n_tests++;
        if (out1() !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_a1 got %b want %b", out1(), 5'd0);
        end
        cyc(1'b0, 8'd50, 1'b1);
        n_tests++;
        if (out1() !== 5'b101_1_0) begin
            n_fail++;
            $display("FAIL mid_b1 got %b want %b", out1(), 5'b101_1_0);
        end
    endtask

    task automatic test_random();
        logic [7:0] i;
        logic       e, r;
        for (int n = 0; n < 400; n++) begin
            i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) i = 8'd0;
            if ($urandom_range(0, 3) == 0) i = i >> $urandom_range(1, 7);
            e = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 24) == 0);
            cyc(r, i, e);
            n_tests++;
            if (out0() !== exp0) begin
                n_fail++;
                $display("FAIL rnd0 n=%0d got %b want %b", n, out0(), exp0);
            end
            n_tests++;
            if (out1() !== exp1) begin
                n_fail++;
                $display("FAIL rnd1 n=%0d got %b want %b", n, out1(), exp1);
            end
            n_tests++;
            if ((bus0.GS & bus0.EO) !== 1'b0 ||
                (bus1.GS & bus1.EO) !== 1'b0) begin
                n_fail++;
                $display("FAIL gs_eo n=%0d got %b%b/%b%b want no 11",
                         n, bus0.GS, bus0.EO, bus1.GS, bus1.EO);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_priority();
        test_zero_walk();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
